// File: rtl/password_lookup.sv
// Read-side account lookup: scans the flash RAM for a requested account and
// hands the matching encrypted password to an external AES-128 decryption core.
module password_lookup #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [DATA_W-1:0]     master_key,
  input  logic [DATA_W-1:0]     account,
  input  logic [ADDR_W-1:0]     max_address,
  input  logic [2*DATA_W-1:0]   data_flash,
  output logic [ADDR_W-1:0]     add_flash,
  output logic                  dec_start,
  output logic [DATA_W-1:0]     dec_key,
  output logic [DATA_W-1:0]     dec_in,
  input  logic                  dec_done,
  input  logic [DATA_W-1:0]     dec_out,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [DATA_W-1:0]     password
);

  typedef struct packed {
    logic [DATA_W-1:0] acct;
    logic [DATA_W-1:0] pw;
  } flash_word_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CMP  = 3'd2,
    DEC  = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  flash_word_t        rd;
  logic [DATA_W-1:0]  acct_q, acct_d;
  logic [ADDR_W-1:0]  max_q, max_d;
  logic [ADDR_W-1:0]  add_d;
  logic               dec_start_d, busy_d, done_d, found_d;
  logic [DATA_W-1:0]  key_d, in_d, pw_d;
  logic               hit_c;

  assign rd = flash_word_t'(data_flash);

  // An all-zero account marks an empty slot and can never match.
  assign hit_c = (rd.acct == acct_q) && (acct_q != '0);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    acct_d      = acct_q;
    max_d       = max_q;
    add_d       = add_flash;
    dec_start_d = 1'b0;
    key_d       = dec_key;
    in_d        = dec_in;
    done_d      = 1'b0;
    found_d     = found;
    pw_d        = password;

    case (state_q)
      IDLE: begin
        if (go) begin
          acct_d  = account;
          key_d   = master_key;
          max_d   = max_address;
          add_d   = '0;
          found_d = 1'b0;
          pw_d    = '0;
          state_d = READ;
        end
      end
      READ: state_d = CMP;
      CMP: begin
        if (hit_c) begin
          in_d        = rd.pw;
          dec_start_d = 1'b1;
          state_d     = DEC;
        end else if (add_flash == max_q) begin
          found_d = 1'b0;
          pw_d    = '0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          add_d   = ADDR_W'(add_flash + 1'b1);
          state_d = READ;
        end
      end
      // dec_done may coincide with the dec_start cycle.
      DEC: begin
        if (dec_done) begin
          pw_d    = dec_out;
          found_d = 1'b1;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      acct_q    <= '0;
      max_q     <= '0;
      add_flash <= '0;
      dec_start <= 1'b0;
      dec_key   <= '0;
      dec_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      password  <= '0;
    end else begin
      state_q   <= state_d;
      acct_q    <= acct_d;
      max_q     <= max_d;
      add_flash <= add_d;
      dec_start <= dec_start_d;
      dec_key   <= key_d;
      dec_in    <= in_d;
      busy      <= busy_d;
      done      <= done_d;
      found     <= found_d;
      password  <= pw_d;
    end
  end

endmodule

// File: tb/tb_password_lookup.sv
// Bench for password_lookup: flash RAM and decryption core models, a fixed
// vector table, hand-written reset/back-to-back sequences and random lookups.
module tb_password_lookup;

  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic [127:0] master_key;
  logic [127:0] account;
  logic [3:0]   max_address;
  logic [255:0] data_flash;
  logic [3:0]   add_flash;
  logic         dec_start;
  logic [127:0] dec_key;
  logic [127:0] dec_in;
  logic         dec_done;
  logic [127:0] dec_out;
  logic         busy;
  logic         done;
  logic         found;
  logic [127:0] password;

  int n_chk  = 0;
  int n_pass = 0;

  logic [255:0] ram [16];

  // Decryption core model knobs
  int   core_lat   = 2;
  bit   core_en    = 1'b1;
  bit   force_done = 1'b0;
  int   core_cnt;
  bit   core_pend;
  logic core_pulse;

  localparam logic [127:0] A   = 128'h61626364;
  localparam logic [127:0] A0  = 128'h1111;
  localparam logic [127:0] A1  = 128'h2222;
  localparam logic [127:0] A2  = 128'h3333;
  localparam logic [127:0] B   = 128'hDEADBEEF;
  localparam logic [127:0] KEY = 128'h000102030405060708090A0B0C0D0E0F;

  password_lookup dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .master_key  (master_key),
    .account     (account),
    .max_address (max_address),
    .data_flash  (data_flash),
    .add_flash   (add_flash),
    .dec_start   (dec_start),
    .dec_key     (dec_key),
    .dec_in      (dec_in),
    .dec_done    (dec_done),
    .dec_out     (dec_out),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .password    (password)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] core_f(input logic [127:0] ct, input logic [127:0] key);
    return ct ^ {key[63:0], key[127:64]} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  endfunction

  // Registered-read RAM
  always @(posedge clk) data_flash <= ram[add_flash];

  // Decryption core: dec_done core_lat cycles after dec_start (0 = same cycle)
  always @(posedge clk) begin
    if (!rst) begin
      core_cnt   <= 0;
      core_pend  <= 1'b0;
      core_pulse <= 1'b0;
    end else begin
      core_pulse <= 1'b0;
      if (dec_start && core_en && core_lat > 0) begin
        if (core_lat == 1) core_pulse <= 1'b1;
        else begin
          core_pend <= 1'b1;
          core_cnt  <= core_lat - 1;
        end
      end else if (core_pend) begin
        if (core_cnt == 1) begin
          core_pulse <= 1'b1;
          core_pend  <= 1'b0;
        end else core_cnt <= core_cnt - 1;
      end
    end
  end

  assign dec_done = (core_en && core_lat == 0 && dec_start) || core_pulse || force_done;
  assign dec_out  = core_f(dec_in, dec_key);

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_add"},  256'(add_flash), 256'(0));
    chk({tag, "_ctl"},  256'({dec_start, busy, done, found}), 256'(0));
    chk({tag, "_key"},  256'(dec_key), 256'(0));
    chk({tag, "_in"},   256'(dec_in), 256'(0));
    chk({tag, "_pw"},   256'(password), 256'(0));
  endtask

  task automatic load_fixed_ram();
    for (int i = 0; i < 16; i++) begin
      if (i < 10) ram[i] = {128'h4000 + 128'(i), 128'hC000 + 128'(i)};
      else        ram[i] = {128'h0, 128'hE000 + 128'(i)};
    end
    ram[0] = {A0, 128'hC0C0};
    ram[1] = {A1, 128'hC1C1};
    ram[2] = {A2, 128'hC2C2};
    ram[3] = {A,  128'hCCCC_0003};
    ram[7] = {A2, 128'hC7C7};
  endtask

  // First matching address in 0..mx; account 0 never matches
  task automatic ref_find(input logic [127:0] acct, input logic [3:0] mx,
                          output bit f, output int addr);
    f = 1'b0;
    addr = 0;
    for (int k = 0; k <= int'(mx); k++) begin
      if (!f && acct != 128'h0 && ram[k][255:128] == acct) begin
        f = 1'b1;
        addr = k;
      end
    end
  endtask

  task automatic run_lookup(input string tag, input logic [127:0] acct, input logic [127:0] key,
                            input logic [3:0] mx, input int lat, input bit hold,
                            input logic [127:0] alt, input bit exp_found, input int exp_addr,
                            input int exp_done);
    int           cyc, done_cyc, start_cyc, n_start, walk_err, last, exp_add;
    logic [127:0] seen_in, seen_key, exp_pw, exp_ct, f_pw, f_key;
    logic         f_found;
    exp_ct   = ram[exp_addr][127:0];
    exp_pw   = exp_found ? core_f(exp_ct, key) : 128'h0;
    last     = exp_found ? exp_addr : int'(mx);
    done_cyc = -1; start_cyc = -1; n_start = 0; walk_err = 0;
    seen_in = '0; seen_key = '0; f_pw = '0; f_key = '0; f_found = 1'b0;
    core_lat    = lat;
    account     = acct;
    master_key  = key;
    max_address = mx;
    go          = 1'b1;
    @(posedge clk); #1;
    if (!hold) go = 1'b0;
    for (cyc = 1; cyc < 120; cyc++) begin
      if (cyc == 1) chk({tag, "_clr"}, 256'({found, password}), 256'(0));
      if (hold && cyc == 4) begin
        account     = alt;
        master_key  = ~key;
        max_address = 4'd0;
      end
      if (dec_start) begin
        n_start++;
        start_cyc = cyc;
        seen_in   = dec_in;
        seen_key  = dec_key;
      end
      exp_add = (cyc - 1) / 2;
      if (exp_add > last) exp_add = last;
      if (add_flash !== 4'(exp_add)) walk_err++;
      if (done) begin
        done_cyc = cyc;
        f_found  = found;
        f_pw     = password;
        f_key    = dec_key;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_done_cyc"}, 256'(done_cyc), 256'(exp_done));
    chk({tag, "_nstart"}, 256'(n_start), 256'(exp_found ? 1 : 0));
    if (exp_found) begin
      chk({tag, "_start_cyc"}, 256'(start_cyc), 256'(3 + 2 * exp_addr));
      chk({tag, "_dec_in"}, 256'(seen_in), 256'(exp_ct));
      chk({tag, "_dec_key_s"}, 256'(seen_key), 256'(key));
    end
    chk({tag, "_found"}, 256'(f_found), 256'(exp_found));
    chk({tag, "_pw"}, 256'(f_pw), 256'(exp_pw));
    chk({tag, "_dec_key"}, 256'(f_key), 256'(key));
    chk({tag, "_walk"}, 256'(walk_err), 256'(0));
    @(posedge clk); #1;
    chk({tag, "_hold"}, 256'({busy, done, found, password}), 256'({2'b00, exp_found, exp_pw}));
  endtask

  typedef struct {
    logic [127:0] acct;
    logic [3:0]   mx;
    int           lat;
    bit           exp_found;
    int           exp_addr;
    int           exp_done;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int           bad;
    bit           rf;
    int           ra, rl;
    logic [127:0] pool [6];
    logic [127:0] racct, rkey;
    logic [3:0]   rmx;

    vecs[0] = '{A,    4'd5,  2, 1'b1, 3, 12};
    vecs[1] = '{B,    4'd15, 2, 1'b0, 0, 33};
    vecs[2] = '{A0,   4'd0,  1, 1'b1, 0, 5};
    vecs[3] = '{A1,   4'd0,  1, 1'b0, 0, 3};
    vecs[4] = '{A2,   4'd15, 0, 1'b1, 2, 8};
    vecs[5] = '{'0,   4'd15, 1, 1'b0, 0, 33};
    vecs[6] = '{A0,   4'd15, 3, 1'b1, 0, 7};
    vecs[7] = '{A2,   4'd1,  0, 1'b0, 0, 5};
    vecs[8] = '{A,    4'd3,  0, 1'b1, 3, 10};

    rst = 1'b0; go = 1'b0; master_key = '0; account = '0; max_address = '0;
    load_fixed_ram();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_lookup($sformatf("vec%0d", i), vecs[i].acct, KEY, vecs[i].mx, vecs[i].lat,
                 1'b0, '0, vecs[i].exp_found, vecs[i].exp_addr, vecs[i].exp_done);

    // Reset while in READ
    account = A; master_key = KEY; max_address = 4'd5; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_zero("rst_read");
    rst = 1'b1;
    bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) bad++;
    end
    chk("rst_read_quiet", 256'(bad), 256'(0));
    run_lookup("after_rst_read", A0, KEY, 4'd15, 1, 1'b0, '0, 1'b1, 0, 5);

    // Reset while in DEC, then a stray dec_done
    core_en = 1'b0;
    account = A; master_key = KEY; max_address = 4'd5; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("dec_wait", 256'({busy, add_flash}), 256'({1'b1, 4'd3}));
    rst = 1'b0;
    @(posedge clk); #1;
    chk_zero("rst_dec");
    rst = 1'b1;
    force_done = 1'b1;
    @(posedge clk); #1;
    force_done = 1'b0;
    bad = 0;
    repeat (5) begin
      if (done || busy || found || password != 0) bad++;
      @(posedge clk); #1;
    end
    chk("rst_dec_late_done", 256'(bad), 256'(0));
    core_en = 1'b1;
    run_lookup("after_rst_dec", A, KEY, 4'd5, 2, 1'b0, '0, 1'b1, 3, 12);

    // go held throughout with inputs changed mid-search, then back-to-back
    run_lookup("hold1", A, KEY, 4'd5, 2, 1'b1, A0, 1'b1, 3, 12);
    run_lookup("b2b", A0, ~KEY, 4'd0, 1, 1'b0, '0, 1'b1, 0, 5);

    // Random lookups against the reference model
    pool[0] = '0;
    for (int i = 1; i < 6; i++) pool[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 16; i++)
        ram[i] = {pool[$urandom_range(0, 4)], $urandom(), $urandom(), $urandom(), $urandom()};
      racct = pool[$urandom_range(0, 5)];
      rkey  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rmx   = 4'($urandom_range(0, 15));
      rl    = int'($urandom_range(0, 3));
      ref_find(racct, rmx, rf, ra);
      run_lookup($sformatf("rnd%0d", it), racct, rkey, rmx, rl, 1'b0, '0, rf, ra,
                 rf ? (3 + 2 * ra + rl + 1) : (3 + 2 * int'(rmx)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/password_lookup.md
Name: password_lookup

Overview:
- Read-side counterpart of the password-store path. It searches the 16-entry flash RAM for a requested account and hands the stored encrypted password to an external AES-128 decryption core, keyed by the master key.
- Returns the plaintext password with found/done status.
- Sits beside the store path and shares the RAM read port (add_flash/data_flash).

Parameters:
ADDR_W, 4, flash address width (16 entries)
DATA_W, 128, account/password/key width; flash word is 2*DATA_W

Ports:
clk  input  1  system clock
rst  input  1  reset (synchronous, active-low)
go  input  1  start lookup; sampled only in IDLE
master_key  input  128  decryption key, latched on accepted go
account  input  128  account to search for, latched on accepted go
max_address  input  4  last flash address to search (inclusive), latched on accepted go
data_flash  input  256  RAM read data; [255:128]=account, [127:0]=encrypted password
add_flash  output  4  RAM read address
dec_start  output  1  one-cycle start pulse to decryption core
dec_key  output  128  key to decryption core (latched master_key)
dec_in  output  128  ciphertext to decryption core
dec_done  input  1  decryption core result valid (one-cycle pulse)
dec_out  input  128  decryption core plaintext
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
found  output  1  result flag, valid from done until next accepted go
password  output  128  decrypted password; zero when not found

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst). rst=0 at a rising edge forces IDLE and zeroes every output and latch: add_flash, dec_start, dec_key, dec_in, busy, done, found, password. This applies in any state, including mid-search and mid-decrypt; a dec_done arriving after reset is ignored.
- RAM read latency: data_flash reflects the add_flash value from the previous cycle (registered read, 1 cycle).
- FSM states: IDLE, READ, CMP, DEC, FIN.
- IDLE:
  - On go=1: latch account, master_key, max_address; add_flash<=0; clear found and password; go to READ.
  - go while not IDLE is ignored.
- READ: wait one cycle for RAM data; go to CMP.
- CMP:
  - Match when data_flash[255:128]==latched account and latched account!=0. All-zero account is the empty-slot marker and never matches.
  - On match: dec_in<=data_flash[127:0]; dec_start=1 for exactly the next cycle; go to DEC.
  - Else if add_flash==latched max_address: found<=0, password<=0; go to FIN.
  - Else add_flash<=add_flash+1; go to READ.
  - First (lowest-address) match wins.
  - Search never wraps: max_address=15 scans 0..15 and stops.
  - max_address=0 scans only address 0.
- DEC:
  - Wait for dec_done. On dec_done: password<=dec_out, found<=1; go to FIN.
  - dec_done arriving in the same cycle as dec_start is legal and accepted.
  - No timeout.
- FIN: done=1 for this cycle only; go to IDLE. A go sampled in the following IDLE cycle starts a new lookup. found and password hold until then.
- Timing, go sampled at cycle 0:
  - Address k is compared in cycle 2+2k.
  - Miss over M+1 entries: done high at cycle 3+2M.
  - Hit at k: dec_start high at cycle 3+2k; done high the cycle after dec_done.
- add_flash holds its last value in IDLE/FIN; it is reset to 0 only by rst or a new go.
- dec_key is stable from accepted go until the next accepted go.

Test Plan:
1. Hit:
   - Stimulus: RAM[3]={A=128'h61626364,C}; RAM[0..2] hold other non-zero accounts; go with account=A, max_address=5; core returns dec_out=P two cycles after dec_start.
   - Required: dec_start at cycle 9, dec_in=C, dec_key=master_key; done one cycle after dec_done; found=1; password=P; busy low after done.
2. Miss:
   - Stimulus: no entry matches; max_address=15.
   - Required: add_flash walks 0..15 with no wrap; dec_start never asserted; done at cycle 33; found=0; password=0.
3. Boundary:
   - Stimulus a: max_address=0 with match at address 0. Required: dec_start at cycle 3.
   - Stimulus b: match only at address 1 with max_address=0. Required: done at cycle 3, found=0.
   - Stimulus c: duplicate account at addresses 2 and 7. Required: dec_in taken from address 2.
   - Stimulus d: account=0 with empty slots present. Required: found=0.
4. Reset mid-operation:
   - Stimulus: assert rst=0 for one cycle while in READ, and separately while in DEC; then pulse dec_done.
   - Required: all outputs 0, busy=0, no done pulse; late dec_done ignored; next go searches from address 0.
5. go while busy, and back-to-back lookups:
   - Stimulus: hold go=1 throughout a lookup; change account mid-search.
   - Required: latched values are unaffected; after FIN, a second lookup starts in the IDLE cycle; found/password from the first lookup are cleared on the second accept.
